dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder for the pipelined core's Memory stage; the slave end of the controller's MemWriteM / MemtoRegM memory interface.
- Accepts word loads and stores from the M stage and holds them for a programmable number of wait states.
- Drives a busy/stall signal back to the hazard logic, then completes the access.
- Lets the pipeline be exercised against slow memory without modifying the controller.

Parameters:
- DEPTH_WORDS, 64: number of 32-bit words in the array; power of two, at least 4.
- WAIT_CYCLES, 2: busy cycles inserted before each access completes. 0 means single-cycle access.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- MemWriteM  input  1  store request from the M stage.
- MemtoRegM  input  1  load request from the M stage.
- ALUOutM  input  32  byte address of the access.
- WriteDataM  input  32  store data.
- ReadDataM  output  32  load data; valid only while MemDoneM=1.
- MemBusyM  output  1  stall request to the hazard unit; the M stage must hold its inputs stable while this is 1.
- MemDoneM  output  1  one-cycle completion pulse.
- MemErrM  output  1  address-range error. Exists only with DMEM_ERR_EN; tied to 0 otherwise.

Behaviour:
- Request and address decode:
  - Req = MemWriteM | MemtoRegM.
  - If both are 1 the access is treated as a store.
  - Word index = ALUOutM[log2(DEPTH_WORDS)+1:2]. ALUOutM[1:0] is ignored, so accesses are word-aligned. Upper bits are ignored, so addresses wrap modulo the array size.
- State machine: states IDLE and WAIT, with counter cnt of width clog2(WAIT_CYCLES+1), minimum 1 bit.
- IDLE, Req=1, WAIT_CYCLES>0: MemBusyM=1 combinationally in the same cycle; next state WAIT, cnt<=1.
- IDLE, Req=1, WAIT_CYCLES=0: complete in this cycle.
  - MemBusyM=0, MemDoneM=1.
  - Load: ReadDataM = array[index], combinational.
  - Store: the array is written at the end of the cycle.
- WAIT, Req=1, cnt<WAIT_CYCLES: MemBusyM=1, cnt<=cnt+1.
- WAIT, Req=1, cnt==WAIT_CYCLES: complete.
  - MemBusyM=0, MemDoneM=1, ReadDataM valid.
  - Store is committed at the end of the cycle.
  - Next state IDLE.
- Busy/latency:
  - Exactly WAIT_CYCLES busy cycles per access.
  - Completion occurs in cycle WAIT_CYCLES, counting the first presentation of the request as cycle 0.
- WAIT, Req=0 (flush or squash): abort. Next state IDLE, no array write, MemDoneM=0, MemBusyM=0.
- Back-to-back accesses:
  - The cycle after a completion is always handled from IDLE.
  - A request present then is a new access and starts a fresh wait sequence.
  - No request is ever completed twice.
- Inputs changing during WAIT: the address and data sampled in the completion cycle are used. Changing them mid-wait is a protocol violation; no checking is done unless DMEM_ERR_EN is defined.
- Outputs when idle or not completing: ReadDataM=0, MemDoneM=0.
- Reset (asynchronous):
  - State IDLE, cnt=0.
  - MemBusyM=0, MemDoneM=0, ReadDataM=0, MemErrM=0.
  - An in-flight access is dropped with no write.
  - Array contents are not reset.
- Read-after-write: a load completing in the cycle after a store's commit returns the new data.

Optional Feature:
- Macro: DMEM_ERR_EN.
- Defined:
  - Any ALUOutM bits at or above log2(DEPTH_WORDS)+2 nonzero on a completing access: MemErrM=1 for that cycle; the store is suppressed and the load returns 0.
  - The address changing between cycle 0 and completion also raises MemErrM in the completion cycle, and the access is still completed.
- Not defined: addresses wrap silently and MemErrM is constant 0.

Test Plan:
- WAIT_CYCLES=2, store 0xDEADBEEF to 0x10 -> MemBusyM=1 for 2 cycles, MemDoneM pulses in cycle 2. A following load of 0x10 -> 2 busy cycles, then ReadDataM=0xDEADBEEF with MemDoneM=1.
- WAIT_CYCLES=0, store 0x1234 to 0x8 then load 0x8 on the next cycle -> MemBusyM never asserted, MemDoneM=1 each cycle, ReadDataM=0x1234 in the load cycle.
- WAIT_CYCLES=3, store 0xAAAA to 0x20; deassert Req after 1 busy cycle; then load 0x20 -> no MemDoneM for the aborted access, and the load returns the prior contents (0 after an earlier store of 0).
- WAIT_CYCLES=2, assert reset during WAIT of a store 0x55 to 0x4 -> all outputs 0 immediately, before the next edge. The array is not written; a later load of 0x4 does not return 0x55.
- DEPTH_WORDS=64, store 0x77 to 0x104 -> wraps to index 1; a load of 0x4 returns 0x77. With DMEM_ERR_EN: MemErrM=1, no write, load returns 0.
- Two consecutive loads with WAIT_CYCLES=1 -> pattern busy, done, busy, done; exactly two MemDoneM pulses.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder for the M stage: word loads/stores with WAIT_CYCLES busy cycles.
// Define DMEM_ERR_EN to enable MemErrM address-range and address-stability checking.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic        MemtoRegM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        MemBusyM,
  output logic        MemDoneM,
  output logic        MemErrM
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] WC = CW'(WAIT_CYCLES);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   mem_q [DEPTH_WORDS];

  logic          req, is_store, complete, busy, err, hi_err, wr_en;
  logic [AW-1:0] idx;

  assign req      = MemWriteM | MemtoRegM;
  assign is_store = MemWriteM;
  assign idx      = ALUOutM[AW+1:2];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    busy     = 1'b0;
    if (req) begin
      case (state_q)
        IDLE: begin
          if (WAIT_CYCLES == 0) begin
            complete = 1'b1;
          end else begin
            busy    = 1'b1;
            state_d = WAIT;
            cnt_d   = CW'(1);
          end
        end
        WAIT: begin
          if (cnt_q == WC) begin
            complete = 1'b1;
            state_d  = IDLE;
            cnt_d    = '0;
          end else begin
            busy  = 1'b1;
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end else begin
      // Request withdrawn mid-wait is a squash: drop it without writing.
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

`ifdef DMEM_ERR_EN
  logic [31:0] addr0_q;
  logic        unused_lo;

  assign unused_lo = ^ALUOutM[1:0];
  assign hi_err    = |ALUOutM[31:AW+2];
  assign err       = complete & (hi_err | ((state_q == WAIT) && (ALUOutM != addr0_q)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr0_q <= '0;
    end else if (state_q == IDLE && req) begin
      addr0_q <= ALUOutM;
    end
  end
`else
  logic unused_addr;

  assign unused_addr = ^{ALUOutM[31:AW+2], ALUOutM[1:0]};
  assign hi_err      = 1'b0;
  assign err         = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Array has no reset; an edge seen while reset is high must not commit a store.
  assign wr_en = complete & is_store & ~hi_err & ~reset;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[idx] <= WriteDataM;
    end
  end

  assign MemBusyM  = busy & ~reset;
  assign MemDoneM  = complete & ~reset;
  assign MemErrM   = err & ~reset;
  assign ReadDataM = (complete && !is_store && !hi_err && !reset) ? mem_q[idx] : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (WAIT_CYCLES=2 and WAIT_CYCLES=0 instances).
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWriteM, MemtoRegM;
  logic [31:0] ALUOutM, WriteDataM;

  logic [31:0] d2_rdata, d0_rdata, rdata;
  logic        d2_busy, d0_busy, busy;
  logic        d2_done, d0_done, done;
  logic        d2_err, d0_err, err;
  bit          sel;

  int          nvec = 0;
  int          nerr = 0;
  logic [31:0] sb [$];
  logic [31:0] model [64];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .reset(reset), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .ReadDataM(d2_rdata),
    .MemBusyM(d2_busy), .MemDoneM(d2_done), .MemErrM(d2_err)
  );

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .ReadDataM(d0_rdata),
    .MemBusyM(d0_busy), .MemDoneM(d0_done), .MemErrM(d0_err)
  );

  always_comb begin
    busy  = sel ? d0_busy  : d2_busy;
    done  = sel ? d0_done  : d2_done;
    err   = sel ? d0_err   : d2_err;
    rdata = sel ? d0_rdata : d2_rdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_cycle(input string tag);
    MemWriteM = 1'b0;
    MemtoRegM = 1'b0;
    @(negedge clk);
    chk({tag, ".busy"}, {31'b0, busy}, 32'd0);
    chk({tag, ".done"}, {31'b0, done}, 32'd0);
    chk({tag, ".rdata"}, rdata, 32'd0);
    @(posedge clk); #1;
  endtask

  // Drives one access and checks the busy/done pattern; leaves inputs asserted.
  task automatic access(input string tag, input bit wr, input bit rd,
                        input logic [31:0] addr, input logic [31:0] data);
    int unsigned wc;
    logic [5:0]  i;
    bit          e;
    wc = sel ? 0 : 2;
    i  = addr[7:2];
`ifdef DMEM_ERR_EN
    e = |addr[31:8];
`else
    e = 1'b0;
`endif
    MemWriteM  = wr;
    MemtoRegM  = rd;
    ALUOutM    = addr;
    WriteDataM = data;
    sb.push_back((wr || e) ? 32'd0 : model[i]);
    for (int unsigned c = 0; c <= wc; c++) begin
      @(negedge clk);
      if (c < wc) begin
        chk({tag, ".busy"}, {31'b0, busy}, 32'd1);
        chk({tag, ".nodone"}, {31'b0, done}, 32'd0);
      end else begin
        chk({tag, ".free"}, {31'b0, busy}, 32'd0);
        chk({tag, ".done"}, {31'b0, done}, 32'd1);
        chk({tag, ".err"}, {31'b0, err}, {31'b0, e});
        chk({tag, ".rdata"}, rdata, sb.pop_front());
      end
      @(posedge clk); #1;
    end
    if (wr && !e) model[i] = data;
  endtask

  initial begin
    reset = 1'b1;
    MemWriteM = 1'b0; MemtoRegM = 1'b0; ALUOutM = '0; WriteDataM = '0;
    sel = 1'b0;
    #3;
    chk("rst.busy", {31'b0, busy}, 32'd0);
    chk("rst.done", {31'b0, done}, 32'd0);
    chk("rst.err", {31'b0, err}, 32'd0);
    chk("rst.rdata", rdata, 32'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    access("st10", 1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
    access("ld10", 1'b0, 1'b1, 32'h10, 32'h0);
    idle_cycle("idle0");

    access("st20", 1'b1, 1'b0, 32'h20, 32'h0);
    MemWriteM = 1'b1; ALUOutM = 32'h20; WriteDataM = 32'hAAAA;
    @(negedge clk);
    chk("abort.busy0", {31'b0, busy}, 32'd1);
    @(posedge clk); #1;
    MemWriteM = 1'b0;
    @(negedge clk);
    chk("abort.busy", {31'b0, busy}, 32'd0);
    chk("abort.done", {31'b0, done}, 32'd0);
    @(posedge clk); #1;
    access("ld20", 1'b0, 1'b1, 32'h20, 32'h0);

    access("st04", 1'b1, 1'b0, 32'h4, 32'h11);
    MemWriteM = 1'b1; MemtoRegM = 1'b0; ALUOutM = 32'h4; WriteDataM = 32'h55;
    @(negedge clk);
    chk("rstw.busy0", {31'b0, busy}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("rstw.busy", {31'b0, busy}, 32'd0);
    chk("rstw.done", {31'b0, done}, 32'd0);
    chk("rstw.err", {31'b0, err}, 32'd0);
    chk("rstw.rdata", rdata, 32'd0);
    MemWriteM = 1'b0;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    access("ld04", 1'b0, 1'b1, 32'h4, 32'h0);

    access("stwrap", 1'b1, 1'b0, 32'h104, 32'h77);
    access("ldwrap", 1'b0, 1'b1, 32'h4, 32'h0);
    access("ldhigh", 1'b0, 1'b1, 32'h104, 32'h0);

    access("stboth", 1'b1, 1'b1, 32'h30, 32'hCAFEF00D);
    access("ld30", 1'b0, 1'b1, 32'h30, 32'h0);
    access("b2b1", 1'b0, 1'b1, 32'h10, 32'h0);
    access("b2b2", 1'b0, 1'b1, 32'h30, 32'h0);
    idle_cycle("idle1");

    sel = 1'b1;
    access("z.st08", 1'b1, 1'b0, 32'h8, 32'h1234);
    access("z.ld08", 1'b0, 1'b1, 32'h8, 32'h0);
    access("z.st0c", 1'b1, 1'b0, 32'hC, 32'h5A5A5A5A);
    access("z.ld0c", 1'b0, 1'b1, 32'hC, 32'h0);
    idle_cycle("z.idle");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
